// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates an instruction-fetch port and a data port onto one memory port, round-robin on conflict.
// Latency: grant on the edge that samples a request in IDLE, ack one cycle after mem_ready is sampled; >= 3 cycles per access.
// Backpressure: requesters hold req until their ack; mem_ready stretches the bus phase; busy stalls the pipeline.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

    // last_grant encoding: 0 = fetch side, 1 = data side
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        pick_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        busy_q, busy_d;

    // Next-state and next-output logic; every output is a flop so values here appear one cycle later
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pick_d       = 1'b0;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        case (state_q)
            IDLE: begin
                // Data side wins when alone, or on conflict when fetch was granted last
                pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));
                if (pick_d) begin
                    state_d      = BUS_D;
                    last_grant_d = GRANT_D;
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                    mem_wstrb_d  = d_we ? d_wstrb : 4'b0000;
                end else if (i_req) begin
                    state_d      = BUS_I;
                    last_grant_d = GRANT_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = 32'h0;
                    mem_wstrb_d  = 4'b0000;
                end
            end
            BUS_I: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = mem_rdata;
                end
            end
            BUS_D: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    // Writes complete without disturbing the last read value
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            busy_q       <= busy_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed stimulus for the memory port arbiter with an ack scoreboard.
// Latency: expected completions are queued at grant and popped when an ack appears.
// Backpressure: memory wait states are driven per transaction from the stimulus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'b0000;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    typedef struct packed {
        logic        side;   // 0 = fetch, 1 = data
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_i_rdata = 32'h0;
    logic [31:0] model_d_rdata = 32'h0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack pops the oldest expected completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_ack && d_ack) begin
                checks++;
                errors++;
                $display("FAIL both_acks: got i_ack=1 d_ack=1 expected at most one");
            end else if (i_ack || d_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected no ack", i_ack, d_ack);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_side", {31'h0, d_ack}, {31'h0, e.side});
                    check("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    task automatic start_i(input logic [31:0] addr);
        i_req  = 1'b1;
        i_addr = addr;
    endtask

    task automatic start_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_wstrb = wstrb;
    endtask

    // Waits for the grant, checks the bus, inserts wait states, and checks RESP and the cycle after
    task automatic serve(input logic side, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input int waits,
                         input logic [31:0] rdata, input bit drop_early);
        int          n;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        exp_t        e;
        exp_we    = side & we;
        exp_wstrb = (side && we) ? wstrb : 4'b0000;
        exp_wdata = side ? wdata : 32'h0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req && n < 20);
        check("grant_mem_req", {31'h0, mem_req}, 32'h1);
        if (!mem_req) return;
        check("grant_mem_addr", mem_addr, addr);
        check("grant_mem_we", {31'h0, mem_we}, {31'h0, exp_we});
        check("grant_mem_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_wstrb});
        check("grant_mem_wdata", mem_wdata, exp_wdata);
        check("grant_busy", {31'h0, busy}, 32'h1);
        e.side = side;
        if (!side) begin
            model_i_rdata = rdata;
            e.data = rdata;
        end else begin
            if (!we) model_d_rdata = rdata;
            e.data = model_d_rdata;
        end
        sb_q.push_back(e);
        if (drop_early) begin
            if (side) d_req = 1'b0;
            else      i_req = 1'b0;
        end
        for (int k = 0; k < waits; k++) begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_0000 | k;
            tick();
            check("wait_hold", {mem_req, mem_we, mem_wstrb, i_ack, d_ack, 24'h0},
                  {1'b1, exp_we, exp_wstrb, 1'b0, 1'b0, 24'h0});
            check("wait_addr", mem_addr, addr);
            check("wait_wdata", mem_wdata, exp_wdata);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        // RESP: keep mem_ready high with junk data, it must be ignored
        mem_rdata = 32'hA5A5_A5A5;
        check("resp_mem_req", {31'h0, mem_req}, 32'h0);
        check("resp_busy", {31'h0, busy}, 32'h1);
        check("resp_acks", {30'h0, d_ack, i_ack}, side ? 32'h2 : 32'h1);
        if (side) d_req = 1'b0;
        else      i_req = 1'b0;
        tick();
        mem_ready = 1'b0;
        check("post_busy", {31'h0, busy}, 32'h0);
        check("post_acks", {30'h0, d_ack, i_ack}, 32'h0);
        check("post_i_rdata", i_rdata, model_i_rdata);
        check("post_d_rdata", d_rdata, model_d_rdata);
    endtask

    initial begin
        int n;
        // Reset and reset values
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_outputs", {mem_req, mem_we, mem_wstrb, i_ack, d_ack, busy, 23'h0}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);

        // Spurious mem_ready in IDLE
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_spurious", {mem_req, busy, i_ack, d_ack, 28'h0}, 32'h0);
        end
        mem_ready = 1'b0;
        check("idle_rdata_hold", i_rdata | d_rdata, 32'h0);

        // Conflict after reset: data first, then fetch wins the next conflict
        start_i(32'h0000_0020);
        start_d(1'b0, 32'h0000_2000, 32'h0, 4'b0000);
        serve(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 0, 32'h1111_2222, 1'b0);
        start_d(1'b0, 32'h0000_2004, 32'h0, 4'b0000);
        serve(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 1, 32'h3333_4444, 1'b0);
        serve(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'b0000, 0, 32'h5555_6666, 1'b0);

        // Single fetch with no wait state
        start_i(32'h0000_0010);
        serve(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, 32'h0050_0093, 1'b0);

        // Write with 3 wait cycles; d_rdata keeps 0x55556666
        start_d(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        serve(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 32'h7777_8888, 1'b0);

        // Read with 5 wait cycles
        start_d(1'b0, 32'h0000_3000, 32'h0, 4'b0000);
        serve(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b0000, 5, 32'hCAFE_F00D, 1'b0);

        // Requester drops req mid-transaction: still completes
        start_i(32'h0000_0040);
        serve(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 2, 32'h0BAD_CAFE, 1'b1);

        // Reset during BUS_D with memory stalled
        start_d(1'b0, 32'h0000_4000, 32'h0, 4'b0000);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req && n < 20);
        check("rstmid_grant", {31'h0, mem_req}, 32'h1);
        d_req = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        model_i_rdata = 32'h0;
        model_d_rdata = 32'h0;
        check("rstmid_outputs", {mem_req, busy, i_ack, d_ack, 28'h0}, 32'h0);
        check("rstmid_d_rdata", d_rdata, 32'h0);
        check("rstmid_mem_addr", mem_addr, 32'h0);
        repeat (2) begin
            tick();
            check("rstmid_quiet", {mem_req, busy, i_ack, d_ack, 28'h0}, 32'h0);
        end
        start_i(32'h0000_0080);
        serve(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'b0000, 1, 32'h1234_5678, 1'b0);

        repeat (3) tick();
        check("scoreboard_empty", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
